nn_image_loader: RTL and testbench

// - Writer side of the neural_network image interface: receives a framed byte stream and fills the 784-pixel buffer.
// - Drives the buffer onto the network's img input, then resets and enables the network.
// - Waits for NN_done, latches the recognised digit and returns to idle for the next frame.
// - Sits between the byte source (UART RX / host bridge) and neural_network.

---
 rtl/nn_image_loader.sv | 129 ++++++++++++
 tb/tb_nn_image_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_image_loader.sv
// nn_image_loader: writer side of the neural_network image interface.
// Collects a framed byte stream (SYNC_BYTE followed by N_PIXELS pixel bytes)
// into the img buffer, pulses the network reset, runs the network until it
// reports done and latches the recognised digit.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rx_data/rx_valid    incoming byte stream
//   rx_ready            high in IDLE and LOAD; byte accepted on valid&&ready
//   img                 pixel buffer driven to neural_network img
//   nn_reset/nn_enable  control of neural_network
//   nn_done/nn_digit    completion and result from neural_network
//   digit_out/digit_vld last recognised digit, 1-cycle update pulse
//   frame_err           1-cycle pulse, frame aborted on byte timeout
//   nn_err              1-cycle pulse, network watchdog expired
//   busy                state != IDLE
module nn_image_loader #(
  parameter int unsigned N_PIXELS     = 784,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT = 100000,
  parameter int unsigned NN_TIMEOUT   = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] img [0:N_PIXELS-1],
  output logic       nn_reset,
  output logic       nn_enable,
  input  logic       nn_done,
  input  logic [7:0] nn_digit,
  output logic [7:0] digit_out,
  output logic       digit_vld,
  output logic       frame_err,
  output logic       nn_err,
  output logic       busy
);

  localparam int unsigned PIX_W = 10;
  localparam int unsigned CNT_W = 18;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_PIXELS - 1);
  localparam logic [CNT_W-1:0] BYTE_TO  = CNT_W'(BYTE_TIMEOUT);
  localparam logic [CNT_W-1:0] NN_TO    = CNT_W'(NN_TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD, NN_RST, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [PIX_W-1:0]   pix_cnt;
  logic [CNT_W-1:0]   idle_cnt;
  logic [CNT_W-1:0]   wd_cnt;
  logic               accept;
  logic               byte_to;
  logic               wd_to;

  assign accept  = rx_valid && rx_ready;
  assign byte_to = (idle_cnt == BYTE_TO);
  assign wd_to   = (wd_cnt == NN_TO);

  // State-decoded outputs
  assign rx_ready  = (state == IDLE) || (state == LOAD);
  assign busy      = (state != IDLE);
  assign nn_enable = (state == RUN);
  assign digit_vld = (state == DONE);
  assign nn_reset  = reset || (state == NN_RST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an accepted byte wins over a same-cycle byte timeout,
  // and nn_done wins over a same-cycle watchdog expiry
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept && (rx_data == SYNC_BYTE)) state_nxt = LOAD;
      LOAD: begin
        if (accept) begin
          if (pix_cnt == LAST_PIX) state_nxt = NN_RST;
        end else if (byte_to) begin
          state_nxt = IDLE;
        end
      end
      NN_RST: state_nxt = RUN;
      RUN: begin
        if (nn_done)    state_nxt = DONE;
        else if (wd_to) state_nxt = IDLE;
      end
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel counter, saturating timeout counters, result and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt   <= '0;
      idle_cnt  <= '0;
      wd_cnt    <= '0;
      digit_out <= '0;
      frame_err <= 1'b0;
      nn_err    <= 1'b0;
    end else begin
      if ((state == IDLE) && accept && (rx_data == SYNC_BYTE))
        pix_cnt <= '0;
      else if ((state == LOAD) && accept && (pix_cnt != LAST_PIX))
        pix_cnt <= pix_cnt + PIX_W'(1);

      if ((state != LOAD) || accept) idle_cnt <= '0;
      else if (!byte_to)             idle_cnt <= idle_cnt + CNT_W'(1);

      if (state != RUN)  wd_cnt <= '0;
      else if (!wd_to)   wd_cnt <= wd_cnt + CNT_W'(1);

      if ((state == RUN) && nn_done) digit_out <= nn_digit;

      frame_err <= (state == LOAD) && !accept && byte_to;
      nn_err    <= (state == RUN) && !nn_done && wd_to;
    end
  end

  // Pixel buffer: not reset, only overwritten while loading
  always_ff @(posedge clk) begin
    if ((state == LOAD) && accept) img[pix_cnt] <= rx_data;
  end

endmodule

// File: tb/tb_nn_image_loader.sv
// Directed self-checking bench for nn_image_loader (timeouts shortened).
module tb_nn_image_loader;

  localparam int unsigned NP  = 784;
  localparam int unsigned BTO = 40;
  localparam int unsigned NTO = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] img [0:NP-1];
  logic       nn_reset;
  logic       nn_enable;
  logic       nn_done;
  logic [7:0] nn_digit;
  logic [7:0] digit_out;
  logic       digit_vld;
  logic       frame_err;
  logic       nn_err;
  logic       busy;

  logic [7:0] exp_img [0:NP-1];
  int n_checks = 0;
  int n_fail   = 0;

  nn_image_loader #(
    .N_PIXELS(NP), .SYNC_BYTE(8'hA5), .BYTE_TIMEOUT(BTO), .NN_TIMEOUT(NTO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .img(img), .nn_reset(nn_reset), .nn_enable(nn_enable),
    .nn_done(nn_done), .nn_digit(nn_digit), .digit_out(digit_out),
    .digit_vld(digit_vld), .frame_err(frame_err), .nn_err(nn_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [7:0] pat(input int mode, input int k);
    case (mode)
      0: return 8'(k);
      1: return (k == 10) ? 8'hA5 : 8'(k ^ 32'h5A);
      2: return 8'(k * 7 + 3);
      default: return 8'(255 - k);
    endcase
  endfunction

  function automatic int img_errs();
    int e = 0;
    for (int i = 0; i < int'(NP); i++) if (img[i] !== exp_img[i]) e++;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Sends SYNC then npix pattern bytes, tracking the expected buffer
  task automatic load_frame(input int mode, input int npix);
    send_byte(8'hA5);
    for (int k = 0; k < npix; k++) begin
      send_byte(pat(mode, k));
      exp_img[k] = pat(mode, k);
    end
  endtask

  // From a RUN cycle: raise nn_done for one cycle, count digit_vld cycles
  task automatic run_to_done(input logic [7:0] d, output int vld_cycles);
    vld_cycles = 0;
    nn_digit = d;
    nn_done  = 1'b1;
    tick();
    nn_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (digit_vld === 1'b1) vld_cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; nn_done = 1'b0; nn_digit = 8'h00;
    repeat (3) tick();
    n_checks++;
    if (nn_reset !== 1'b1 || rx_ready !== 1'b1 || busy !== 1'b0 || nn_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: nn_reset=%b rx_ready=%b busy=%b nn_enable=%b, want 1 1 0 0",
               nn_reset, rx_ready, busy, nn_enable);
    end
    n_checks++;
    if (digit_out !== 8'h00 || digit_vld !== 1'b0 || frame_err !== 1'b0 || nn_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: digit_out=%h vld=%b ferr=%b nerr=%b, want 00 0 0 0",
               digit_out, digit_vld, frame_err, nn_err);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (nn_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: nn_reset=%b want 0", nn_reset);
    end
  endtask

  task automatic test_full_frame();
    int run_bad = 0;
    load_frame(0, NP);
    n_checks++;
    if (nn_reset !== 1'b1 || nn_enable !== 1'b0 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nn_rst_cycle: nn_reset=%b nn_enable=%b rx_ready=%b, want 1 0 0",
               nn_reset, nn_enable, rx_ready);
    end
    tick();
    n_checks++;
    if (nn_reset !== 1'b0 || nn_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL run_entry: nn_reset=%b nn_enable=%b, want 0 1", nn_reset, nn_enable);
    end
    n_checks++;
    if (img_errs() != 0 || img[783] !== 8'h0F) begin
      n_fail++;
      $display("FAIL img_frame1: %0d bad pixels, img[783]=%h want 0f", img_errs(), img[783]);
    end
    repeat (3) begin
      if (nn_enable !== 1'b1 || digit_vld !== 1'b0) run_bad++;
      tick();
    end
    n_checks++;
    if (run_bad != 0) begin
      n_fail++;
      $display("FAIL run_hold: %0d bad cycles want 0", run_bad);
    end
    nn_digit = 8'd7;
    nn_done  = 1'b1;
    tick();
    nn_done  = 1'b0;
    n_checks++;
    if (digit_vld !== 1'b1 || digit_out !== 8'd7 || nn_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle: vld=%b digit=%0d en=%b, want 1 7 0", digit_vld, digit_out, nn_enable);
    end
    tick();
    n_checks++;
    if (digit_vld !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL back_idle: vld=%b busy=%b rx_ready=%b, want 0 0 1", digit_vld, busy, rx_ready);
    end
  endtask

  task automatic test_discard();
    int v;
    nn_digit = 8'h44;
    nn_done  = 1'b1;
    tick();
    nn_done  = 1'b0;
    n_checks++;
    if (digit_vld !== 1'b0 || digit_out !== 8'd7 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_in_idle: vld=%b digit=%0d busy=%b, want 0 7 0", digit_vld, digit_out, busy);
    end
    send_byte(8'h00);
    send_byte(8'h13);
    n_checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL discard: busy=%b rx_ready=%b, want 0 1", busy, rx_ready);
    end
    load_frame(1, NP);
    tick();
    n_checks++;
    if (img_errs() != 0 || img[10] !== 8'hA5 || img[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL img_frame2: %0d bad, img[10]=%h want a5, img[0]=%h want 5a",
               img_errs(), img[10], img[0]);
    end
    run_to_done(8'd3, v);
    n_checks++;
    if (digit_out !== 8'd3 || v != 1) begin
      n_fail++;
      $display("FAIL digit_frame2: digit=%0d vld_cycles=%0d, want 3 1", digit_out, v);
    end
  endtask

  task automatic test_byte_timeout();
    int n = 0;
    int v;
    load_frame(2, 100);
    while (frame_err !== 1'b1 && n < int'(BTO) + 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != int'(BTO) + 1) begin
      n_fail++;
      $display("FAIL byte_timeout_lat: frame_err after %0d cycles want %0d", n, BTO + 1);
    end
    n_checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%b rx_ready=%b, want 0 1", busy, rx_ready);
    end
    n_checks++;
    if (img_errs() != 0 || img[100] !== 8'h3E) begin
      n_fail++;
      $display("FAIL partial_img: %0d bad, img[100]=%h want 3e", img_errs(), img[100]);
    end
    tick();
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err_pulse: frame_err=%b want 0", frame_err);
    end
    load_frame(3, NP);
    tick();
    run_to_done(8'd5, v);
    n_checks++;
    if (digit_out !== 8'd5 || v != 1 || img_errs() != 0) begin
      n_fail++;
      $display("FAIL recover_frame: digit=%0d vld_cycles=%0d bad_pix=%0d, want 5 1 0",
               digit_out, v, img_errs());
    end
  endtask

  task automatic test_nn_timeout();
    int n = 0;
    load_frame(0, NP);
    tick();
    while (nn_err !== 1'b1 && n < int'(NTO) + 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != int'(NTO) + 1) begin
      n_fail++;
      $display("FAIL nn_timeout_lat: nn_err after %0d cycles want %0d", n, NTO + 1);
    end
    n_checks++;
    if (digit_out !== 8'd5 || busy !== 1'b0 || nn_enable !== 1'b0 || digit_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL nn_timeout_state: digit=%0d busy=%b en=%b vld=%b, want 5 0 0 0",
               digit_out, busy, nn_enable, digit_vld);
    end
    tick();
    n_checks++;
    if (nn_err !== 1'b0) begin
      n_fail++;
      $display("FAIL nn_err_pulse: nn_err=%b want 0", nn_err);
    end
  endtask

  task automatic test_rx_blocked();
    int blocked = 0;
    load_frame(2, NP);
    tick();
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    repeat (10) begin
      if (rx_ready !== 1'b0) blocked++;
      tick();
    end
    n_checks++;
    if (blocked != 0) begin
      n_fail++;
      $display("FAIL rx_blocked: rx_ready high %0d cycles in RUN want 0", blocked);
    end
    nn_digit = 8'd9;
    nn_done  = 1'b1;
    tick();
    nn_done  = 1'b0;
    rx_valid = 1'b0;
    tick();
    n_checks++;
    if (img_errs() != 0 || digit_out !== 8'd9 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL img_stable: bad_pix=%0d digit=%0d busy=%b, want 0 9 0",
               img_errs(), digit_out, busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    load_frame(0, 400);
    reset = 1'b1;
    #1;
    n_checks++;
    if (nn_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL nn_reset_in_reset_load: nn_reset=%b want 1", nn_reset);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || digit_out !== 8'd0 || rx_ready !== 1'b1 ||
        digit_vld !== 1'b0 || frame_err !== 1'b0 || nn_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_load: busy=%b digit=%0d rdy=%b vld=%b ferr=%b nerr=%b, want 0 0 1 0 0 0",
               busy, digit_out, rx_ready, digit_vld, frame_err, nn_err);
    end
    reset = 1'b0;
    n_checks++;
    if (img_errs() != 0) begin
      n_fail++;
      $display("FAIL img_after_reset: %0d bad pixels want 0", img_errs());
    end
    load_frame(3, NP);
    tick();
    n_checks++;
    if (nn_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL run_before_reset: nn_enable=%b want 1", nn_enable);
    end
    nn_digit = 8'd4;
    reset = 1'b1;
    #1;
    n_checks++;
    if (nn_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL nn_reset_in_reset_run: nn_reset=%b want 1", nn_reset);
    end
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || nn_enable !== 1'b0 || digit_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b en=%b digit=%0d, want 0 0 0", busy, nn_enable, digit_out);
    end
    repeat (5) begin
      if (digit_vld !== 1'b0 || frame_err !== 1'b0 || nn_err !== 1'b0 || busy !== 1'b0) pulses++;
      tick();
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL no_pulses_after_reset: %0d bad cycles want 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_discard();
    test_byte_timeout();
    test_nn_timeout();
    test_rx_blocked();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
